// File: rtl/hfifo.sv
// Elastic FIFO between two 4-phase bundled-data channels.
// Optional input synchronisers let either neighbour run off clk.
module hfifo #(
  parameter int N = 1,
  parameter int DEPTH = 2,
  parameter int SYNC = 2,
  parameter logic [N-1:0] RdataVal = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       r_i,
  output logic                       a_i,
  input  logic [N-1:0]               d_i,
  output logic                       r_o,
  input  logic                       a_o,
  output logic [N-1:0]               d_o,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [AW-1:0] LAST = AW'(DEPTH-1);
  localparam logic [CW-1:0] FULLV = CW'(DEPTH);

  typedef enum logic {IN_IDLE, IN_ACK} in_st_e;
  typedef enum logic [1:0] {
    OUT_IDLE, OUT_REQ, OUT_RTZ
  } out_st_e;

  logic r_s, a_s;

  if (SYNC == 0) begin : g_nosync
    assign r_s = r_i;
    assign a_s = a_o;
  end else begin : g_sync
    logic [SYNC-1:0] r_sync_q, r_sync_d;
    logic [SYNC-1:0] a_sync_q, a_sync_d;

    always_comb begin
      r_sync_d = r_sync_q;
      a_sync_d = a_sync_q;
      r_sync_d[0] = r_i;
      a_sync_d[0] = a_o;
      for (int i = 1; i < SYNC; i++) begin
        r_sync_d[i] = r_sync_q[i-1];
        a_sync_d[i] = a_sync_q[i-1];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_sync_q <= '0;
        a_sync_q <= '0;
      end else begin
        r_sync_q <= r_sync_d;
        a_sync_q <= a_sync_d;
      end
    end

    assign r_s = r_sync_q[SYNC-1];
    assign a_s = a_sync_q[SYNC-1];
  end

  in_st_e in_st_q, in_st_d;
  out_st_e out_st_q, out_st_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic full_q, full_d;
  logic empty_q, empty_d;
  logic a_i_q, a_i_d;
  logic r_o_q, r_o_d;
  logic [N-1:0] d_o_q, d_o_d;
  logic [N-1:0] mem_q [DEPTH];
  logic push, pop;

  always_comb begin
    in_st_d = in_st_q;
    a_i_d = a_i_q;
    push = 1'b0;
    unique case (in_st_q)
      IN_IDLE: begin
        if (r_s && !full_q) begin
          push = 1'b1;
          a_i_d = 1'b1;
          in_st_d = IN_ACK;
        end
      end
      IN_ACK: begin
        if (!r_s) begin
          a_i_d = 1'b0;
          in_st_d = IN_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    out_st_d = out_st_q;
    r_o_d = r_o_q;
    d_o_d = d_o_q;
    pop = 1'b0;
    unique case (out_st_q)
      OUT_IDLE: begin
        if (!empty_q && !a_s) begin
          d_o_d = mem_q[rptr_q];
          r_o_d = 1'b1;
          out_st_d = OUT_REQ;
        end
      end
      OUT_REQ: begin
        if (a_s) begin
          r_o_d = 1'b0;
          pop = 1'b1;
          out_st_d = OUT_RTZ;
        end
      end
      OUT_RTZ: begin
        if (!a_s) out_st_d = OUT_IDLE;
      end
      default: begin
        r_o_d = 1'b0;
        out_st_d = OUT_IDLE;
      end
    endcase
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    count_d = count_q;
    if (push) wptr_d = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
    if (pop) rptr_d = (rptr_q == LAST) ? '0 : rptr_q + 1'b1;
    unique case ({push, pop})
      2'b10: count_d = count_q + 1'b1;
      2'b01: count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d = (count_d == FULLV);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_st_q <= IN_IDLE;
      out_st_q <= OUT_IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      a_i_q <= 1'b0;
      r_o_q <= 1'b0;
      d_o_q <= RdataVal;
    end else begin
      in_st_q <= in_st_d;
      out_st_q <= out_st_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      full_q <= full_d;
      empty_q <= empty_d;
      a_i_q <= a_i_d;
      r_o_q <= r_o_d;
      d_o_q <= d_o_d;
    end
  end

  // Storage is never read before written, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= d_i;
  end

  assign a_i = a_i_q;
  assign r_o = r_o_q;
  assign d_o = d_o_q;
  assign count = count_q;
  assign full = full_q;
  assign empty = empty_q;

endmodule
